// File: rtl/cic_pkg.sv
// Shared sizing, types and the output rounding/saturation helper used by the
// DFE filter array's output stages (here: the CIC decimator).
package cic_pkg;

   localparam int DATA_WIDTH_DEF   = 16;
   localparam int N_STAGES_DEF     = 5;
   localparam int MAX_DEC_LOG2_DEF = 4;

   // Hogenauer register growth: N stages of gain R each, R up to 2^max_dec_log2.
   function automatic int acc_w(input int data_width, input int n_stages, input int max_dec_log2);
      return data_width + n_stages * max_dec_log2;
   endfunction

   localparam int ACC_W_DEF = acc_w(DATA_WIDTH_DEF, N_STAGES_DEF, MAX_DEC_LOG2_DEF);

   typedef logic signed [ACC_W_DEF-1:0] acc_t;

   typedef struct packed {
      logic signed [63:0] value;
      logic               ovf;
      logic               unf;
   } sat_res_t;

   // Round half-up, arithmetic shift right, then clamp to a signed 'width'-bit range.
   function automatic sat_res_t round_sat(input logic signed [63:0] x, input int shift,
                                          input int width);
      sat_res_t           res;
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = x;
      if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
      r  = r >>> shift;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      res.ovf   = (r > hi);
      res.unf   = (r < lo);
      res.value = res.ovf ? hi : (res.unf ? lo : r);
      return res;
   endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One wrapping CIC integrator: adds din_i into the accumulator on en_i,
// synchronous clear on rst or clr_i.
module cic_integrator_stage #(
   parameter int W = 36
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic signed [W-1:0] din_i,
   output logic signed [W-1:0] acc_o
);

   logic signed [W-1:0] acc_q;
   logic signed [W-1:0] acc_d;

   always_comb begin
      // NOTE: acc_d gets a default before any branch, so no path leaves it unassigned (no latch).
      acc_d = acc_q;
      if (clr_i)     acc_d = '0;
      else if (en_i) acc_d = acc_q + din_i;  // wraps modulo 2^W; combs undo it exactly
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every stage in the chain samples its neighbour's pre-edge value.
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/cic_decimator.sv
// Programmable N-stage CIC decimator (R = 2^dec_log2) with rounded, saturated
// output, registered bypass and flush on decimation-factor writes.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int DATA_FRAC    = 15,
   parameter int N_STAGES     = N_STAGES_DEF,
   parameter int MAX_DEC_LOG2 = MAX_DEC_LOG2_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_in,
   input  logic                         bypass,
   input  logic                         dec_wr_en,
   input  logic [2:0]                   dec_log2_in,
   input  logic signed [DATA_WIDTH-1:0] cic_in,
   output logic signed [DATA_WIDTH-1:0] cic_out,
   output logic                         overflow,
   output logic                         underflow,
   output logic                         valid_out
);

   localparam int         ACC_W  = acc_w(DATA_WIDTH, N_STAGES, MAX_DEC_LOG2);
   localparam int         PH_W   = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
   localparam logic [2:0] MAX_L2 = 3'(MAX_DEC_LOG2);

   logic [2:0]              dec_q, dec_d;
   logic [PH_W-1:0]         phase_q, phase_d, phase_last;
   logic                    flush, accept, tick;
   logic signed [ACC_W-1:0] x_ext, last_next;
   logic signed [ACC_W-1:0] stage_in [N_STAGES];
   logic signed [ACC_W-1:0] integ    [N_STAGES];
   logic signed [ACC_W-1:0] comb_c   [N_STAGES+1];
   logic signed [ACC_W-1:0] comb_d_q [N_STAGES];
   int                      acc_frac, shift_s;
   sat_res_t                sat;
   logic                    unused_sat_hi;

   logic signed [DATA_WIDTH-1:0] out_q;
   logic                         ovf_q, unf_q, vld_q;

   assign flush      = dec_wr_en | bypass;
   assign accept     = valid_in & ~flush;
   assign phase_last = PH_W'((1 << dec_q) - 1);
   assign tick       = accept && (phase_q == phase_last);
   assign x_ext      = {{(ACC_W-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};

   for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
      if (k == 0) begin : g_first
         assign stage_in[k] = x_ext;
      end else begin : g_rest
         assign stage_in[k] = integ[k-1];
      end
      cic_integrator_stage #(.W(ACC_W)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .clr_i (flush),
         .en_i  (accept),
         .din_i (stage_in[k]),
         .acc_o (integ[k])
      );
   end

   // The comb chain sees the last integrator's value as updated by this sample.
   assign last_next = integ[N_STAGES-1] + stage_in[N_STAGES-1];

   always_comb begin
      comb_c[0] = last_next;
      for (int k = 0; k < N_STAGES; k++) comb_c[k+1] = comb_c[k] - comb_d_q[k];
      acc_frac = DATA_FRAC + N_STAGES * int'(dec_q);
      shift_s  = acc_frac - DATA_FRAC;
      sat      = round_sat({{(64-ACC_W){comb_c[N_STAGES][ACC_W-1]}}, comb_c[N_STAGES]},
                           shift_s, DATA_WIDTH);
   end

   // Above DATA_WIDTH the clamped value is only sign copies.
   assign unused_sat_hi = ^sat.value[63:DATA_WIDTH];

   always_comb begin
      dec_d   = dec_q;
      phase_d = phase_q;
      if (dec_wr_en) dec_d = (dec_log2_in > MAX_L2) ? MAX_L2 : dec_log2_in;
      if (flush)       phase_d = '0;
      else if (accept) phase_d = tick ? '0 : phase_q + PH_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_q   <= 3'd2;
         phase_q <= '0;
      end else begin
         dec_q   <= dec_d;
         phase_q <= phase_d;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the comb delays form a small register array that must clear on every flush,
      // so each element is reset explicitly instead of being treated as uninitialised memory.
      if (rst || flush) begin
         for (int k = 0; k < N_STAGES; k++) comb_d_q[k] <= '0;
      end else if (tick) begin
         for (int k = 0; k < N_STAGES; k++) comb_d_q[k] <= comb_c[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         vld_q <= 1'b0;
      end else if (dec_wr_en) begin
         vld_q <= 1'b0;
      end else if (bypass) begin
         vld_q <= valid_in;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         if (valid_in) out_q <= cic_in;
      end else begin
         vld_q <= tick;
         if (tick) begin
            out_q <= sat.value[DATA_WIDTH-1:0];
            ovf_q <= sat.ovf;
            unf_q <= sat.unf;
         end
      end
   end

   assign cic_out   = out_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign valid_out = vld_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transfer-function (boxcar^N) reference model.
module tb_cic_decimator;

   localparam int N = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic        bypass = 1'b0;
   logic        dec_wr_en = 1'b0;
   logic [2:0]  dec_log2_in = 3'd0;
   logic [15:0] cic_in = 16'h0;
   logic [15:0] cic_out;
   logic        overflow, underflow, valid_out;

   always #5 clk = ~clk;

   cic_decimator dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .bypass      (bypass),
      .dec_wr_en   (dec_wr_en),
      .dec_log2_in (dec_log2_in),
      .cic_in      (cic_in),
      .cic_out     (cic_out),
      .overflow    (overflow),
      .underflow   (underflow),
      .valid_out   (valid_out)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int          m_l2;
   int          hist[$];   // accepted samples since the last flush
   longint      h[$];      // impulse response of (1 + z^-1 + ... + z^-(R-1))^N
   logic [15:0] m_out;
   bit          m_valid, m_ovf, m_unf;

   function automatic void set_l2(input int l2);
      longint cur[$];
      longint nxt[$];
      int     r;
      m_l2 = (l2 > 4) ? 4 : l2;
      r    = 1 << m_l2;
      cur  = {64'sd1};
      for (int s = 0; s < N; s++) begin
         nxt = {};
         for (int i = 0; i < cur.size() + r - 1; i++) begin
            longint acc = 0;
            for (int t = 0; t < r; t++)
               if (i - t >= 0 && i - t < cur.size()) acc += cur[i-t];
            nxt.push_back(acc);
         end
         cur = nxt;
      end
      h = cur;
   endfunction

   function automatic void model_tick();
      int     n = hist.size() - 1;
      longint y = 0;
      longint yr;
      longint s;
      s = longint'(N * m_l2);
      for (int j = 0; j < h.size(); j++) begin
         int idx = n - (N - 1) - j;
         if (idx >= 0) y += h[j] * longint'(hist[idx]);
      end
      yr      = (s > 0) ? ((y + (longint'(1) <<< (s - 1))) >>> s) : y;
      m_ovf   = (yr > 32767);
      m_unf   = (yr < -32768);
      m_out   = m_ovf ? 16'h7fff : (m_unf ? 16'h8000 : 16'(yr));
      m_valid = 1'b1;
   endfunction

   task automatic compare_outputs(input string tag);
      check({tag, "_valid"}, valid_out, m_valid);
      check({tag, "_out"}, cic_out, m_out);
      check({tag, "_flags"}, {overflow, underflow}, {m_ovf, m_unf});
   endtask

   task automatic drive(input bit v, input logic [15:0] x, input bit byp = 1'b0,
                        input bit wr = 1'b0, input logic [2:0] l2 = 3'd0);
      rst = 1'b0; valid_in = v; cic_in = x; bypass = byp; dec_wr_en = wr; dec_log2_in = l2;
      if (wr) begin
         set_l2(int'(l2));
         hist.delete();
         m_valid = 1'b0;
      end else if (byp) begin
         hist.delete();
         m_valid = v;
         if (v) m_out = x;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (v) begin
            hist.push_back(int'($signed(x)));
            if (hist.size() % (1 << m_l2) == 0) model_tick();
         end
      end
      @(posedge clk); #1;
      compare_outputs("model");
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b1; bypass = 1'b0; dec_wr_en = 1'b0; cic_in = 16'h7777;
      set_l2(2);
      hist.delete();
      m_valid = 1'b0; m_out = 16'h0; m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      compare_outputs("reset");
      rst = 1'b0; valid_in = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          rst, v, byp, wr;
      logic [2:0]  l2;
      logic [15:0] din;
      bit          e_valid;
      logic [15:0] e_out;
   } vec_t;

   vec_t        tbl[17];
   logic [15:0] imp_exp[8];
   logic [15:0] samples[16];
   int          pulses, outs;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h5555, 1'b0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h7fff, 1'b1, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h7fff};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h1234, 1'b1, 16'h1234};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h1234};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 16'h1111, 1'b0, 16'h1234};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h2222, 1'b0, 16'h0000};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h4000, 1'b0, 16'h0000};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h4000, 1'b0, 16'h0000};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h4000, 1'b0, 16'h0000};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h4000, 1'b1, 16'h0000};

      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst; valid_in = tbl[i].v; bypass = tbl[i].byp;
         dec_wr_en = tbl[i].wr; dec_log2_in = tbl[i].l2; cic_in = tbl[i].din;
         @(posedge clk); #1;
         check($sformatf("tbl%0d_valid", i), valid_out, tbl[i].e_valid);
         check($sformatf("tbl%0d_out", i), cic_out, tbl[i].e_out);
         check($sformatf("tbl%0d_flags", i), {overflow, underflow}, 2'b00);
      end

      do_reset();

      // DC 0x4000 at R = 4.
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd2);
      pulses = 0; outs = 0;
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 16'h4000);
         if (valid_out) begin
            pulses++; outs++;
            if (outs >= 7) check("dc_r4_settled", cic_out, 16'h4000);
         end
      end
      check("dc_r4_pulses", pulses, 16);

      // Impulse at R = 1.
      imp_exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h7fff, 16'h0, 16'h0, 16'h0};
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i == 0) ? 16'h7fff : 16'h0000);
         check($sformatf("impulse%0d_out", i), cic_out, imp_exp[i]);
         check($sformatf("impulse%0d_valid", i), valid_out, 1'b1);
      end

      // Full-scale DC at R = 16.
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd4);
      for (int i = 0; i < 160; i++) drive(1'b1, 16'h8000);
      check("r16_min_settled", cic_out, 16'h8000);
      check("r16_min_valid", valid_out, 1'b1);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd4);
      for (int i = 0; i < 160; i++) drive(1'b1, 16'h7fff);
      check("r16_max_settled", cic_out, 16'h7fff);
      check("r16_max_flags", {overflow, underflow}, 2'b00);

      // Reconfigure mid-group: R 4 -> 8 with valid_in high in the write cycle.
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd2);
      drive(1'b1, 16'h0100);
      drive(1'b1, 16'h0200);
      drive(1'b1, 16'h0300, 1'b0, 1'b1, 3'd3);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'(i * 64));
         check($sformatf("reconf%0d_valid", i), valid_out, (i == 7));
      end

      // Bypass, then gap-free versus gapped input at R = 2.
      drive(1'b1, 16'h1234, 1'b1);
      check("bypass_out", cic_out, 16'h1234);
      check("bypass_valid", valid_out, 1'b1);
      for (int i = 0; i < 16; i++) samples[i] = 16'($urandom);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd1);
      for (int i = 0; i < 16; i++) drive(1'b1, samples[i]);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd1);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, samples[i]);
         drive(1'b0, 16'hdead);
      end

      // Reset mid-operation, then DC run at the reset factor R = 4.
      drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd3);
      for (int i = 0; i < 5; i++) drive(1'b1, 16'h3000);
      do_reset();
      for (int i = 0; i < 64; i++) drive(1'b1, 16'h4000);
      check("post_reset_settled", cic_out, 16'h4000);

      // Randomized traffic.
      for (int seg = 0; seg < 30; seg++) begin
         bit byp_seg;
         byp_seg = ($urandom_range(0, 5) == 0);
         drive(1'b0, 16'h0, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
         for (int c = 0; c < 60; c++) begin
            int          r;
            logic [15:0] x;
            r = $urandom_range(0, 199);
            case ($urandom_range(0, 3))
               0:       x = 16'h8000;
               1:       x = 16'h7fff;
               default: x = 16'($urandom);
            endcase
            if (r == 0) do_reset();
            else drive($urandom_range(0, 3) != 0, x, byp_seg && (c < 8), (r < 3),
                       3'($urandom_range(0, 7)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
